// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array output path: column width, collector
// FSM states and the packed {col2, col1} row layout.
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } collector_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] col2;
        logic [DATA_W-1:0] col1;
    } row_t;

endpackage

// File: rtl/sys_row_fifo.sv
// Synchronous show-ahead FIFO for de-skewed rows: head_data is the oldest entry
// whenever empty is low. Pointers carry one extra wrap bit to separate full from empty.
module sys_row_fifo
    import tpu_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level     = wr_ptr_q - rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers; reset empties the FIFO and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sys_output_collector.sv
// De-skews the two bottom-row systolic column outputs into rows, buffers them and
// reports job completion. Define SYS_COLLECTOR_RELU_EN to zero negative column values.
module sys_output_collector
    import tpu_pkg::*;
#(
    parameter int DATA_W     = tpu_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     col_data_in_1,
    input  logic                  col_valid_in_1,
    input  logic [DATA_W-1:0]     col_data_in_2,
    input  logic                  col_valid_in_2,
    input  logic [1:0]            col_mask_in,
    input  logic [ROWS_W-1:0]     expected_rows_in,
    input  logic                  start_in,
    output logic [2*DATA_W-1:0]   out_row_data,
    output logic                  out_row_valid,
    input  logic                  out_row_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int ROW_W = 2 * DATA_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ROWS_W-1:0] CNT_ONE = {{(ROWS_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]  LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};

    collector_state_e   state_q, state_d;
    logic [ROWS_W-1:0]  expected_q, expected_d;
    logic [ROWS_W-1:0]  row_cnt_q, row_cnt_d;
    logic [1:0]         mask_q, mask_d;
    logic [DATA_W-1:0]  skew_q, skew_d;
    logic               pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               proto_err_q, proto_err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               push;
    logic [ROW_W-1:0]   push_row;
    logic               proto_hit;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [ROW_W-1:0]   fifo_head;

    function automatic logic [DATA_W-1:0] col_filter(input logic [DATA_W-1:0] v);
`ifdef SYS_COLLECTOR_RELU_EN
        if (v[DATA_W-1]) begin
            col_filter = {DATA_W{1'b0}};
        end else begin
            col_filter = v;
        end
`else
        col_filter = v;
`endif
    endfunction

    assign pop  = ~fifo_empty & out_row_ready;
    assign drop = push & fifo_full & ~pop;

    // Column de-skew: column 1 waits in the skew register until column 2 of the same row.
    always_comb begin
        push      = 1'b0;
        push_row  = {ROW_W{1'b0}};
        proto_hit = 1'b0;
        skew_d    = skew_q;
        pending_d = pending_q;
        if (state_q == ST_COLLECT) begin
            case (mask_q)
                2'b11: begin
                    if (col_valid_in_2) begin
                        if (pending_q) begin
                            push      = 1'b1;
                            push_row  = {col_filter(col_data_in_2), col_filter(skew_q)};
                            pending_d = 1'b0;
                        end else begin
                            proto_hit = 1'b1;
                        end
                    end else begin
                        pending_d = pending_q;
                    end
                    // A same-cycle column 1 starts the next row and keeps pending set.
                    if (col_valid_in_1) begin
                        skew_d    = col_data_in_1;
                        pending_d = 1'b1;
                    end else begin
                        skew_d = skew_q;
                    end
                end
                2'b01: begin
                    if (col_valid_in_1) begin
                        push     = 1'b1;
                        push_row = {{DATA_W{1'b0}}, col_filter(col_data_in_1)};
                    end else begin
                        push = 1'b0;
                    end
                end
                default: begin
                    push = 1'b0;
                end
            endcase
        end else begin
            pending_d = 1'b0;
        end
    end

    // Job FSM: arm on start, count row pushes, end once the FIFO has fully drained.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        mask_d      = mask_q;
        row_cnt_d   = row_cnt_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    expected_d  = expected_rows_in;
                    mask_d      = col_mask_in;
                    row_cnt_d   = {ROWS_W{1'b0}};
                    overflow_d  = 1'b0;
                    proto_err_d = 1'b0;
                    if (expected_rows_in == {ROWS_W{1'b0}}) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (push) begin
                    row_cnt_d = row_cnt_q + CNT_ONE;
                end else begin
                    row_cnt_d = row_cnt_q;
                end
                if (drop) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                if (proto_hit) begin
                    proto_err_d = 1'b1;
                end else begin
                    proto_err_d = proto_err_q;
                end
                if (row_cnt_d == expected_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                // Nothing is pushed here, so the FIFO empties when its last row pops.
                if ((fifo_level == {LVL_W{1'b0}}) || ((fifo_level == LVL_ONE) && pop)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            expected_q  <= {ROWS_W{1'b0}};
            mask_q      <= 2'b00;
            row_cnt_q   <= {ROWS_W{1'b0}};
            skew_q      <= {DATA_W{1'b0}};
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            mask_q      <= mask_d;
            row_cnt_q   <= row_cnt_d;
            skew_q      <= skew_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    sys_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_row),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_row_data  = fifo_head;
    assign out_row_valid = ~fifo_empty;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_sys_output_collector.sv
// Scoreboard bench for sys_output_collector: rows are generated first, skewed into
// column streams, and a monitor compares every accepted FIFO row in order.
module tb_sys_output_collector;
    import tpu_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int RW    = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   col_data_in_1 = '0;
    logic            col_valid_in_1 = 1'b0;
    logic [DW-1:0]   col_data_in_2 = '0;
    logic            col_valid_in_2 = 1'b0;
    logic [1:0]      col_mask_in = 2'b11;
    logic [RW-1:0]   expected_rows_in = '0;
    logic            start_in = 1'b0;
    logic [2*DW-1:0] out_row_data;
    logic            out_row_valid;
    logic            out_row_ready = 1'b0;
    logic            busy, done, overflow, proto_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   occ     = 0;
    int   s_cyc   = 0;
    int   done_cnt = 0;
    bit   model_ovf = 1'b0;
    row_t exp_q[$];

    always #5 clk = ~clk;

    sys_output_collector #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ROWS_W(RW)) dut (
        .clk(clk), .rst(rst),
        .col_data_in_1(col_data_in_1), .col_valid_in_1(col_valid_in_1),
        .col_data_in_2(col_data_in_2), .col_valid_in_2(col_valid_in_2),
        .col_mask_in(col_mask_in), .expected_rows_in(expected_rows_in), .start_in(start_in),
        .out_row_data(out_row_data), .out_row_valid(out_row_valid), .out_row_ready(out_row_ready),
        .busy(busy), .done(done), .overflow(overflow), .proto_err(proto_err)
    );

    function automatic logic [15:0] fexp(input logic [15:0] v);
`ifdef SYS_COLLECTOR_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic row_t mk_row(input logic [15:0] c2, input logic [15:0] c1);
        row_t r;
        r.col2 = c2;
        r.col1 = c1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; the model books the completed row (if any) against occupancy.
    task automatic drive(input logic v1, input logic [15:0] d1, input logic v2,
                         input logic [15:0] d2, input logic rdy, input bit push, input row_t r);
        bit pop;
        col_valid_in_1 = v1;
        col_data_in_1  = d1;
        col_valid_in_2 = v2;
        col_data_in_2  = d2;
        out_row_ready  = rdy;
        pop = (occ > 0) && rdy;
        if (push) begin
            if (occ == DEPTH && !pop) begin
                model_ovf = 1'b1;
            end else begin
                exp_q.push_back(r);
                occ++;
            end
        end
        if (pop) occ--;
        @(posedge clk);
        #1;
        start_in = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, rdy, 1'b0, mk_row(16'h0000, 16'h0000));
    endtask

    task automatic start_job(input logic [15:0] n, input logic [1:0] m);
        start_in         = 1'b1;
        expected_rows_in = n;
        col_mask_in      = m;
        model_ovf        = 1'b0;
        s_cyc            = cyc;
        idle(1'b1);
    endtask

    task automatic finish_job(input bit eovf, input bit eperr);
        int k = 0;
        while (!done && k < 64) begin
            idle(1'b1);
            k++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("overflow_end", {31'd0, overflow}, {31'd0, eovf});
        check("proto_err_end", {31'd0, proto_err}, {31'd0, eperr});
        check("busy_end", {31'd0, busy}, 32'd0);
        idle(1'b1);
        check("done_single", {31'd0, done}, 32'd0);
    endtask

    // Random rows are generated first, then laid out as a (possibly overlapping) skewed stream.
    task automatic rand_job(input int nrows, input logic [1:0] mask, input int rdy_pct);
        logic          v1a [64];
        logic          v2a [64];
        logic [15:0]   d1a [64];
        logic [15:0]   d2a [64];
        int            cmp [64];
        row_t          rows [16];
        logic [15:0]   a, b;
        int            s, len;
        row_t          rr;
        for (int c = 0; c < 64; c++) begin
            v1a[c] = 1'b0;
            v2a[c] = (mask == 2'b01) ? 1'($urandom_range(0, 1)) : 1'b0;
            d1a[c] = 16'($urandom);
            d2a[c] = 16'($urandom);
            cmp[c] = -1;
        end
        s = 0;
        len = 0;
        for (int i = 0; i < nrows; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            v1a[s] = 1'b1;
            d1a[s] = a;
            if (mask == 2'b11) begin
                v2a[s+1] = 1'b1;
                d2a[s+1] = b;
                cmp[s+1] = i;
                rows[i]  = mk_row(fexp(b), fexp(a));
                len      = s + 2;
            end else begin
                cmp[s]  = i;
                rows[i] = mk_row(16'h0000, fexp(a));
                len     = s + 1;
            end
            s = s + 1 + $urandom_range(0, 2);
        end
        start_job(16'(nrows), mask);
        for (int c = 0; c < len; c++) begin
            rr = (cmp[c] >= 0) ? rows[cmp[c]] : mk_row(16'h0000, 16'h0000);
            drive(v1a[c], d1a[c], v2a[c], d2a[c], 1'($urandom_range(0, 99) < rdy_pct),
                  cmp[c] >= 0, rr);
        end
        check("overflow_stream", {31'd0, overflow}, {31'd0, model_ovf});
        check("valid_stream", {31'd0, out_row_valid}, {31'd0, occ > 0});
        finish_job(model_ovf, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every handshake pops the oldest expected row.
    initial forever begin
        row_t e;
        @(negedge clk);
        if (!rst) begin
            if (done) done_cnt++;
            if (out_row_valid && out_row_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_row: got 0x%08h, required no row (cycle %0d)", out_row_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", out_row_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int dc;
        int pcts [4];
        logic [31:0] relu_exp;
        pcts = '{100, 70, 30, 0};
`ifdef SYS_COLLECTOR_RELU_EN
        relu_exp = 32'h0003_0000;
`else
        relu_exp = 32'h0003_FFF0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_row_valid}, 32'd0);
        check("rst_data", out_row_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        check("post_rst_valid", {31'd0, out_row_valid}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Mask 11, three overlapping rows, exact latency and done timing.
        start_job(16'd3, 2'b11);
        t = cyc;
        drive(1'b1, 16'd5, 1'b0, 16'd0, 1'b1, 1'b0, mk_row(16'd0, 16'd0));
        drive(1'b1, 16'd7, 1'b1, 16'd6, 1'b1, 1'b1, mk_row(16'd6, 16'd5));
        check("t1_valid_t2", {31'd0, out_row_valid}, 32'd1);
        check("t1_row0_t2", out_row_data, 32'h0006_0005);
        drive(1'b1, 16'd9, 1'b1, 16'd8, 1'b1, 1'b1, mk_row(16'd8, 16'd7));
        check("t1_row1_t3", out_row_data, 32'h0008_0007);
        drive(1'b0, 16'd0, 1'b1, 16'd10, 1'b1, 1'b1, mk_row(16'd10, 16'd9));
        check("t1_row2_t4", out_row_data, 32'h000A_0009);
        check("t1_busy_t4", {31'd0, busy}, 32'd1);
        check("t1_no_done_t4", {31'd0, done}, 32'd0);
        idle(1'b1);
        check("t1_done_t5", {31'd0, done}, 32'd1);
        check("t1_done_cycle", cyc - t, 32'd5);
        idle(1'b1);
        check("t1_done_once", {31'd0, done}, 32'd0);
        check("t1_scoreboard_empty", exp_q.size(), 32'd0);

        // Backpressure: six rows with ready low, four survive.
        rand_job(6, 2'b11, 0);

        // Mask 01: column 2 traffic is ignored.
        start_job(16'd2, 2'b01);
        drive(1'b1, 16'h0011, 1'b1, 16'h1234, 1'b1, 1'b1, mk_row(16'h0000, 16'h0011));
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b1, 16'h0022, 1'b0, 16'h0000, 1'b1, 1'b1, mk_row(16'h0000, 16'h0022));
        finish_job(1'b0, 1'b0);

        // Column 2 with nothing pending.
        start_job(16'd1, 2'b11);
        drive(1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        check("perr_set", {31'd0, proto_err}, 32'd1);
        check("perr_no_push", {31'd0, out_row_valid}, 32'd0);
        drive(1'b1, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 1'b1, mk_row(16'h0008, 16'h0007));
        finish_job(1'b0, 1'b1);

        // Zero-row job: done two cycles after start, sticky flags cleared by start.
        start_job(16'd0, 2'b11);
        check("zero_busy", {31'd0, busy}, 32'd1);
        check("zero_perr_cleared", {31'd0, proto_err}, 32'd0);
        check("zero_no_done_early", {31'd0, done}, 32'd0);
        idle(1'b1);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_done_cycle", cyc - s_cyc, 32'd2);
        idle(1'b1);
        check("zero_idle_busy", {31'd0, busy}, 32'd0);
        check("zero_done_once", {31'd0, done}, 32'd0);

        // start_in while busy is ignored.
        start_job(16'd2, 2'b11);
        drive(1'b1, 16'h0101, 1'b0, 16'h0000, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        start_in = 1'b1;
        expected_rows_in = 16'd1;
        col_mask_in = 2'b01;
        drive(1'b0, 16'h0000, 1'b1, 16'h0202, 1'b1, 1'b1, mk_row(16'h0202, 16'h0101));
        col_mask_in = 2'b11;
        dc = done_cnt;
        repeat (3) idle(1'b1);
        check("restart_ignored_busy", {31'd0, busy}, 32'd1);
        check("restart_ignored_no_done", done_cnt - dc, 32'd0);
        drive(1'b1, 16'h0303, 1'b0, 16'h0000, 1'b1, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b0, 16'h0000, 1'b1, 16'h0404, 1'b1, 1'b1, mk_row(16'h0404, 16'h0303));
        finish_job(1'b0, 1'b0);

        // Reset mid-job with two rows buffered.
        start_job(16'd5, 2'b11);
        drive(1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b1, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b1, mk_row(16'h0002, 16'h0001));
        drive(1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 1'b1, mk_row(16'h0004, 16'h0003));
        check("midrst_buffered", {31'd0, out_row_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_row_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_flags", {30'd0, overflow, proto_err}, 32'd0);
        exp_q.delete();
        occ = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b1);
        rand_job(3, 2'b11, 100);

        // Negative column 1 value with and without the clamp.
        start_job(16'd1, 2'b11);
        drive(1'b1, 16'hFFF0, 1'b0, 16'h0000, 1'b0, 1'b0, mk_row(16'h0000, 16'h0000));
        drive(1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, mk_row(fexp(16'h0003), fexp(16'hFFF0)));
        check("relu_row", out_row_data, relu_exp);
        finish_job(1'b0, 1'b0);

        for (int j = 0; j < 10; j++) begin
            rand_job($urandom_range(1, 8), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01,
                     pcts[$urandom_range(0, 3)]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_output_collector.md
Name: sys_output_collector

Overview:
- Sits directly downstream of the 2x2 systolic array.
- Consumes the two bottom-row column outputs, which arrive skewed by one cycle: column 2 comes one cycle after column 1 for the same input row.
- De-skews them into complete row vectors and buffers them in a small FIFO.
- Presents rows to the unified-buffer write-back path over a valid/ready handshake, and signals done once the programmed number of rows has drained.

Parameters:
- DATA_W, 16, width of one column value (signed two's complement).
- FIFO_DEPTH, 4, row FIFO depth in entries. Must be a power of two, at least 2.
- ROWS_W, 16, width of the row counter and of the expected-row count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- col_data_in_1  in  DATA_W  column 1 result (array output 21)
- col_valid_in_1  in  1  column 1 result valid
- col_data_in_2  in  DATA_W  column 2 result (array output 22)
- col_valid_in_2  in  1  column 2 result valid
- col_mask_in  in  2  enabled columns. Must equal the array's column enable; bit0 = column 1.
- expected_rows_in  in  ROWS_W  number of rows to collect, sampled on start_in
- start_in  in  1  single-cycle arm pulse
- out_row_data  out  2*DATA_W  {column 2, column 1}; a disabled column reads 0
- out_row_valid  out  1  FIFO head valid
- out_row_ready  in  1  downstream accepts head
- busy  out  1  high in COLLECT and DRAIN
- done  out  1  single-cycle pulse at job end
- overflow  out  1  sticky: a row was dropped because the FIFO was full
- proto_err  out  1  sticky: column 2 valid with no pending column 1 value

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - All outputs are 0 during and after reset.
  - FIFO is empty, state is IDLE, counters are 0, sticky flags are cleared.
  - Reset asserted mid-job discards all buffered rows.
- State machine: IDLE -> COLLECT -> DRAIN -> IDLE.
  - IDLE: when start_in is seen, latch expected_rows_in and col_mask_in, clear row_cnt, overflow and proto_err.
    - expected_rows_in = 0: go directly to DRAIN. done pulses the following cycle because the FIFO is empty.
    - Otherwise: go to COLLECT.
  - COLLECT: accept column results as described under de-skew. Each row push increments row_cnt, including a push that is dropped because the FIFO is full. When row_cnt reaches the expected count, go to DRAIN.
  - DRAIN: ignore column inputs. When the FIFO is empty, pulse done for one cycle and return to IDLE.
  - start_in outside IDLE is ignored.
- De-skew (COLLECT only):
  - Mask 11: col_valid_in_1 captures col_data_in_1 into a skew register and sets a pending flag.
    - col_valid_in_2 forms the row {col_data_in_2, skew register}, pushes it, and clears the pending flag.
    - A cycle carrying both valids pushes the previous pending row and re-captures the new column 1 value, keeping the pending flag set.
    - col_valid_in_2 with no pending flag sets proto_err and pushes nothing.
  - Mask 01: col_valid_in_1 pushes {0, col_data_in_1} immediately. col_valid_in_2 is ignored.
  - Mask 00: nothing is collected. The job ends only through expected_rows_in = 0.
- FIFO:
  - Push occurs at the edge that closes the cycle carrying the completing valid. out_row_valid rises the next cycle: latency is 1 cycle from the completing valid when the FIFO is empty.
  - Show-ahead output: out_row_data holds the head whenever out_row_valid is high.
  - Pop happens when out_row_valid and out_row_ready are both high.
  - Push and pop in the same cycle while full is legal: no drop, occupancy unchanged.
  - Push while full without a pop drops the row and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra count bit.
- Arithmetic: data passes through unchanged, except for the optional feature below.

Optional Feature:
- Macro: SYS_COLLECTOR_RELU_EN.
- Defined: each column value with its MSB set is replaced by 0 before the FIFO push. This applies to each column independently and adds no latency.
- Undefined: values pass through as signed data, bit-exact.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_W constant
  - collector state enum typedef (IDLE, COLLECT, DRAIN)
  - row struct typedef {col2, col1}
- One sub-module, sys_row_fifo: a parameterised synchronous show-ahead FIFO with push/pop/full/empty.
- De-skew, counters and the FSM stay in the top module.

Test Plan:
- Mask 11, 3 rows: start with expected=3. Drive col1 = 5, 7, 9 on cycles t, t+1, t+2 and col2 = 6, 8, 10 on t+1..t+3, with ready held high. Required: out_row_data = 0x0006_0005, 0x0008_0007, 0x000A_0009 on t+2..t+4; done pulses once on t+5.
- Backpressure/overflow (FIFO_DEPTH=4): 6 rows with ready held low. Required: 4 rows buffered and overflow set. Release ready: exactly 4 rows drain, then done.
- Mask 01: expected=2, col1 = 0x0011 then 0x0022, col2 toggling. Required: 0x0000_0011, 0x0000_0022; col2 ignored; proto_err stays 0.
- Protocol/edge cases:
  - col2 valid with nothing pending: proto_err = 1 and nothing is pushed.
  - expected=0: done pulses 2 cycles after start_in.
  - start_in while busy: no effect.
- Reset mid-job: assert rst with 2 rows buffered. Required: out_row_valid = 0, busy = 0, flags clear. A subsequent job completes normally.
- SYS_COLLECTOR_RELU_EN: col1 = 0xFFF0, col2 = 0x0003. Required: 0x0003_0000 with the macro defined, 0x0003_FFF0 without it.
